// File: rtl/egd_bit_aligner.sv
// rtl/egd_bit_aligner.sv - 64-bit shift buffer presenting a 16-bit look-ahead window to the exp-Golomb decoder
module egd_bit_aligner #(
  parameter int IN_W  = 32,
  parameter int WIN_W = 16,
  parameter int BUF_W = 64,
  parameter int LEN_W = 5
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIN_W-1:0] win_data,
  output logic             win_valid,
  input  logic             adv_en,
  input  logic [LEN_W-1:0] adv_len,
  input  logic             align_en,
  output logic             align_busy,
  input  logic             flush,
  output logic [31:0]      bit_pos,
  output logic             adv_err
);

  localparam int CNT_W = $clog2(BUF_W + 1);

  // Buffer is MSB-aligned: the oldest unconsumed bit sits at shreg[BUF_W-1],
  // and every bit below bit_cnt is kept at zero so a new word can be OR-ed in.
  logic [BUF_W-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             align_pend;

  logic             adv_ok;
  logic             adv_bad;
  logic             align_go;
  logic [2:0]       align_d;
  logic             accept;
  logic [CNT_W-1:0] sh;
  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W-1:0] cnt_n;
  logic [BUF_W-1:0] buf_s;
  logic [BUF_W-1:0] ins;
  logic [BUF_W-1:0] buf_n;

  assign in_ready   = (bit_cnt <= CNT_W'(BUF_W - IN_W));
  assign win_valid  = (bit_cnt >= CNT_W'(WIN_W));
  assign win_data   = shreg[BUF_W-1 -: WIN_W];
  assign align_busy = align_pend;

  // Next-state datapath: consume (advance or alignment drop) first, then append the new word behind what remains.
  always_comb begin
    adv_ok   = adv_en && win_valid && (adv_len != '0) && (adv_len <= LEN_W'(WIN_W));
    adv_bad  = adv_en && !adv_ok;
    align_d  = 3'(3'd0 - bit_pos[2:0]);
    align_go = align_pend && !adv_en && (bit_cnt >= CNT_W'(8));
    sh       = '0;
    if (adv_ok) begin
      sh = CNT_W'(adv_len);
    end else if (align_go) begin
      sh = CNT_W'(align_d);
    end
    buf_s  = shreg << sh;
    cnt_s  = bit_cnt - sh;
    accept = in_valid && in_ready;
    ins    = {in_data, {(BUF_W - IN_W){1'b0}}} >> cnt_s;
    buf_n  = buf_s;
    cnt_n  = cnt_s;
    if (accept) begin
      buf_n = buf_s | ins;
      cnt_n = cnt_s + CNT_W'(IN_W);
    end
  end

  // State registers; flush behaves like reset but also arrives mid-stream from the slice parser.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || flush) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      bit_pos    <= '0;
      align_pend <= 1'b0;
      adv_err    <= 1'b0;
    end else begin
      shreg      <= buf_n;
      bit_cnt    <= cnt_n;
      bit_pos    <= bit_pos + 32'(sh);
      align_pend <= align_en || (align_pend && !align_go);
      adv_err    <= adv_err || adv_bad;
    end
  end

endmodule

// File: tb/tb_egd_bit_aligner.sv
// tb/tb_egd_bit_aligner.sv - directed scoreboard bench for egd_bit_aligner
module tb_egd_bit_aligner;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] win_data;
  logic        win_valid;
  logic        adv_en;
  logic [4:0]  adv_len;
  logic        align_en;
  logic        align_busy;
  logic        flush;
  logic [31:0] bit_pos;
  logic        adv_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [15:0] wd;
    logic        wv;
    logic        ir;
    logic        ab;
    logic [31:0] bp;
    logic        err;
  } exp_t;

  exp_t sb[$];

  egd_bit_aligner dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .win_data   (win_data),
    .win_valid  (win_valid),
    .adv_en     (adv_en),
    .adv_len    (adv_len),
    .align_en   (align_en),
    .align_busy (align_busy),
    .flush      (flush),
    .bit_pos    (bit_pos),
    .adv_err    (adv_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, queue its expected outcome, then pop and compare after the edge.
  task automatic step(input logic iv, input logic [31:0] id, input logic ae, input logic [4:0] al,
                      input logic aln, input logic fl, input logic rs, input string tag,
                      input logic [15:0] wd, input logic wv, input logic ir, input logic ab,
                      input logic [31:0] bp, input logic err);
    exp_t e;
    in_valid = iv;
    in_data  = id;
    adv_en   = ae;
    adv_len  = al;
    align_en = aln;
    flush    = fl;
    rst      = rs;
    sb.push_back('{tag, wd, wv, ir, ab, bp, err});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    total++;
    assert (win_data === e.wd) else begin
      bad++;
      $error("FAIL %s win_data got=%h exp=%h", e.tag, win_data, e.wd);
    end
    total++;
    assert (win_valid === e.wv) else begin
      bad++;
      $error("FAIL %s win_valid got=%b exp=%b", e.tag, win_valid, e.wv);
    end
    total++;
    assert (in_ready === e.ir) else begin
      bad++;
      $error("FAIL %s in_ready got=%b exp=%b", e.tag, in_ready, e.ir);
    end
    total++;
    assert (align_busy === e.ab) else begin
      bad++;
      $error("FAIL %s align_busy got=%b exp=%b", e.tag, align_busy, e.ab);
    end
    total++;
    assert (bit_pos === e.bp) else begin
      bad++;
      $error("FAIL %s bit_pos got=%0d exp=%0d", e.tag, bit_pos, e.bp);
    end
    total++;
    assert (adv_err === e.err) else begin
      bad++;
      $error("FAIL %s adv_err got=%b exp=%b", e.tag, adv_err, e.err);
    end
  endtask

  initial begin
    //   iv  data          ae  len    al  fl  rst  tag             wd        wv ir ab bp  err
    step(1, 32'h11111111, 1, 5'd4, 1, 0, 1, "reset",        16'h0000, 0, 1, 0, 0,  0);
    step(0, 32'h0,        0, 5'd0, 0, 0, 1, "reset2",       16'h0000, 0, 1, 0, 0,  0);
    // Two words back to back fill the buffer to 64 bits.
    step(1, 32'hA5C30F96, 0, 5'd0, 0, 0, 0, "word1",        16'hA5C3, 1, 1, 0, 0,  0);
    step(1, 32'h12345678, 0, 5'd0, 0, 0, 0, "word2",        16'hA5C3, 1, 0, 0, 0,  0);
    // Advance 5, then byte-align (3-bit drop once the request is registered).
    step(0, 32'h0,        1, 5'd5, 0, 0, 0, "adv5",         16'hB861, 1, 0, 0, 5,  0);
    step(0, 32'h0,        0, 5'd0, 1, 0, 0, "align_req",    16'hB861, 1, 0, 1, 5,  0);
    step(0, 32'h0,        0, 5'd0, 0, 0, 0, "align_done",   16'hC30F, 1, 0, 0, 8,  0);
    // Drain down to 20 buffered bits.
    step(0, 32'h0,        1, 5'd16, 0, 0, 0, "adv16a",      16'h9612, 1, 0, 0, 24, 0);
    step(0, 32'h0,        1, 5'd16, 0, 0, 0, "adv16b",      16'h3456, 1, 1, 0, 40, 0);
    step(0, 32'h0,        1, 5'd4, 0, 0, 0, "adv4",         16'h4567, 1, 1, 0, 44, 0);
    // Advance 16 and accept a word in the same cycle: 20-16+32 = 36 bits.
    step(1, 32'hFFFF0000, 1, 5'd16, 0, 0, 0, "adv_and_word", 16'h8FFF, 1, 0, 0, 60, 0);
    // Illegal lengths / advance without a full window.
    step(0, 32'h0,        1, 5'd17, 0, 0, 0, "adv17_bad",   16'h8FFF, 1, 0, 0, 60, 1);
    step(0, 32'h0,        1, 5'd16, 0, 0, 0, "adv16c",      16'hF000, 1, 1, 0, 76, 1);
    step(0, 32'h0,        1, 5'd10, 0, 0, 0, "adv10",       16'h0000, 0, 1, 0, 86, 1);
    step(0, 32'h0,        1, 5'd3, 0, 0, 0, "adv_nowin",    16'h0000, 0, 1, 0, 86, 1);
    // Flush overrides word, advance and align in the same cycle, and clears adv_err.
    step(1, 32'hCAFEBABE, 1, 5'd4, 1, 1, 0, "flush",        16'h0000, 0, 1, 0, 0,  0);
    // Alignment request held off by three cycles of continuous advance.
    step(1, 32'h12345678, 0, 5'd0, 0, 0, 0, "w_a",          16'h1234, 1, 1, 0, 0,  0);
    step(1, 32'h9ABCDEF0, 0, 5'd0, 0, 0, 0, "w_b",          16'h1234, 1, 0, 0, 0,  0);
    step(0, 32'h0,        1, 5'd3, 1, 0, 0, "hold1",        16'h91A2, 1, 0, 1, 3,  0);
    step(0, 32'h0,        1, 5'd1, 1, 0, 0, "hold2",        16'h2345, 1, 0, 1, 4,  0);
    step(0, 32'h0,        1, 5'd1, 1, 0, 0, "hold3",        16'h468A, 1, 0, 1, 5,  0);
    step(0, 32'h0,        0, 5'd0, 0, 0, 0, "hold_drop",    16'h3456, 1, 0, 0, 8,  0);
    // Reset mid-stream with a word and an advance offered.
    step(1, 32'hFFFFFFFF, 1, 5'd8, 0, 0, 1, "rst_mid",      16'h0000, 0, 1, 0, 0,  0);
    step(0, 32'h0,        0, 5'd0, 0, 0, 0, "rst_idle",     16'h0000, 0, 1, 0, 0,  0);
    // Zero-length advance is illegal even with a full window.
    step(1, 32'hDEADBEEF, 0, 5'd0, 0, 0, 0, "w_dead",       16'hDEAD, 1, 1, 0, 0,  0);
    step(0, 32'h0,        1, 5'd0, 0, 0, 0, "adv0_bad",     16'hDEAD, 1, 1, 0, 0,  1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
